// File: rtl/bambu_slave_initiator.sv
// Command/response initiator for the slave memory port and start/done handshake
// of a Bambu-generated accelerator top; only slave channel 0 is ever driven.
module bambu_slave_initiator #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 64,
  parameter int SIZE_W      = 7,
  parameter int RD_TIMEOUT  = 16,
  parameter int RUN_TIMEOUT = 200000000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_wdata,
  input  logic [SIZE_W-1:0]        cmd_size,
  output logic                     rsp_valid,
  output logic                     rsp_err,
  output logic [32+DATA_W-1:0]     rsp_data,
  output logic                     start_port,
  input  logic                     done_port,
  output logic [1:0]               S_oe_ram,
  output logic [1:0]               S_we_ram,
  output logic [2*ADDR_W-1:0]      S_addr_ram,
  output logic [2*DATA_W-1:0]      S_Wdata_ram,
  output logic [2*SIZE_W-1:0]      S_data_ram_size,
  input  logic [2*DATA_W-1:0]      Sout_Rdata_ram,
  input  logic [1:0]               Sout_DataRdy
);

  localparam int WAIT_W = $clog2(RD_TIMEOUT + 1);
  localparam int RSP_W  = 32 + DATA_W;

  typedef enum logic [2:0] {IDLE, WR, RD, START, RUN, RESP} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                rsp_err_q, rsp_err_d;
  logic [RSP_W-1:0]    rsp_data_q, rsp_data_d;

  // Channel 1 read data and ready are never consumed.
  logic unused_in;
  assign unused_in = ^{Sout_Rdata_ram[2*DATA_W-1:DATA_W], Sout_DataRdy[1]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      wait_q     <= '0;
      cnt_q      <= '0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      wait_q     <= wait_d;
      cnt_q      <= cnt_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    wait_d     = wait_q;
    cnt_d      = cnt_q;
    rsp_err_d  = rsp_err_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          size_d  = cmd_size;
          wait_d  = '0;
          cnt_d   = 32'd1;
          case (cmd_op)
            2'd0:    state_d = WR;
            2'd1:    state_d = RD;
            2'd2:    state_d = START;
            default: begin
              state_d    = RESP;
              rsp_err_d  = 1'b1;
              rsp_data_d = '0;
            end
          endcase
        end
      end
      WR, RD: begin
        if (Sout_DataRdy[0]) begin
          state_d    = RESP;
          rsp_err_d  = 1'b0;
          rsp_data_d = (state_q == RD) ? {32'd0, Sout_Rdata_ram[DATA_W-1:0]} : '0;
        end else if (wait_q == WAIT_W'(RD_TIMEOUT - 1)) begin
          state_d    = RESP;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      START, RUN: begin
        // Counter holds n+1 during cycle Tn, so it is the reported latency as-is.
        if (done_port) begin
          state_d    = RESP;
          rsp_err_d  = 1'b0;
          rsp_data_d = RSP_W'(cnt_q);
        end else if (cnt_q >= 32'(RUN_TIMEOUT)) begin
          state_d    = RESP;
          rsp_err_d  = 1'b1;
          rsp_data_d = RSP_W'(RUN_TIMEOUT);
        end else begin
          state_d = RUN;
          cnt_d   = cnt_q + 32'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready       = (state_q == IDLE);
    rsp_valid       = (state_q == RESP);
    start_port      = (state_q == START);
    S_oe_ram        = 2'b00;
    S_we_ram        = 2'b00;
    S_addr_ram      = '0;
    S_Wdata_ram     = '0;
    S_data_ram_size = '0;
    if (state_q == WR || state_q == RD) begin
      S_we_ram[0]     = (state_q == WR);
      S_oe_ram[0]     = (state_q == RD);
      S_addr_ram      = {{ADDR_W{1'b0}}, addr_q};
      S_data_ram_size = {{SIZE_W{1'b0}}, size_q};
      if (state_q == WR) S_Wdata_ram = {{DATA_W{1'b0}}, wdata_q};
    end
  end

  assign rsp_err  = rsp_err_q;
  assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_bambu_slave_initiator.sv
// Bench for bambu_slave_initiator: per-command expected output timelines built
// from the transaction rules, compared against the DUT on every falling edge.
module tb_bambu_slave_initiator;
  localparam int AW = 9, DW = 64, SW = 7, RDT = 16, RUNT = 40;

  logic              clock = 1'b0;
  logic              reset;
  logic              cmd_valid, cmd_ready;
  logic [1:0]        cmd_op;
  logic [AW-1:0]     cmd_addr;
  logic [DW-1:0]     cmd_wdata;
  logic [SW-1:0]     cmd_size;
  logic              rsp_valid, rsp_err;
  logic [32+DW-1:0]  rsp_data;
  logic              start_port, done_port;
  logic [1:0]        S_oe_ram, S_we_ram;
  logic [2*AW-1:0]   S_addr_ram;
  logic [2*DW-1:0]   S_Wdata_ram;
  logic [2*SW-1:0]   S_data_ram_size;
  logic [2*DW-1:0]   Sout_Rdata_ram;
  logic [1:0]        Sout_DataRdy;

  bambu_slave_initiator #(
    .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .RD_TIMEOUT(RDT), .RUN_TIMEOUT(RUNT)
  ) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .start_port(start_port), .done_port(done_port),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic            ready;
    logic [1:0]      oe;
    logic [1:0]      we;
    logic [2*AW-1:0] addr;
    logic [2*DW-1:0] wdata;
    logic [2*SW-1:0] size;
    logic            start;
    logic            rvalid;
    logic            rerr;
    logic [32+DW-1:0] rdata;
  } obs_t;

  obs_t act_o, exp_o;
  bit   exp_on;
  int   tests, fails, cyc;
  logic             last_err;
  logic [32+DW-1:0] last_data;

  bit               pin_en;
  logic [32+DW-1:0] pin_data;
  logic             pin_err;
  int               pin_strobe, pin_start;
  logic [2*AW-1:0]  pin_addr;

  int              mon_strobe, mon_start;
  logic [2*AW-1:0] mon_addr;

  assign act_o = {cmd_ready, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
                  start_port, rsp_valid, rsp_err, rsp_data};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    obs_t r;
    cyc++;
    if (reset) begin
      r = '0;
      r.ready = 1'b1;
      tests++;
      if (act_o !== r) begin
        fails++;
        $display("FAIL reset_state cyc=%0d actual=%h required=%h", cyc, act_o, r);
      end
    end else if (exp_on) begin
      tests++;
      if (act_o !== exp_o) begin
        fails++;
        $display("FAIL cycle_outputs cyc=%0d actual=%h required=%h", cyc, act_o, exp_o);
      end
      if (exp_o.ready) begin
        mon_strobe = 0;
        mon_start  = 0;
        mon_addr   = '0;
      end else begin
        if (S_we_ram[0] | S_oe_ram[0]) begin
          mon_strobe++;
          mon_addr = S_addr_ram;
        end
        if (start_port) mon_start++;
      end
      if (exp_o.rvalid && pin_en) begin
        chk("pin_rsp_data", rsp_data, pin_data);
        chk("pin_rsp_err", rsp_err, pin_err);
        chk("pin_strobe_cycles", mon_strobe, pin_strobe);
        chk("pin_start_cycles", mon_start, pin_start);
        if (pin_strobe > 0) chk("pin_addr", mon_addr, pin_addr);
        chk("pin_model_data", exp_o.rdata, pin_data);
      end
    end
  end

  function automatic obs_t idle_exp();
    obs_t e = '0;
    e.ready = 1'b1;
    e.rerr  = last_err;
    e.rdata = last_data;
    return e;
  endfunction

  task automatic strays();
    done_port      = 1'($urandom_range(0, 1));
    Sout_DataRdy   = 2'($urandom_range(0, 3));
    Sout_Rdata_ram = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic busy_garbage();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_addr  = AW'($urandom);
    cmd_wdata = {$urandom, $urandom};
    cmd_size  = SW'($urandom);
  endtask

  task automatic idle(input int n, input bit force_stray);
    repeat (n) begin
      @(posedge clock); #1;
      strays();
      cmd_valid = 1'b0;
      if (force_stray) begin
        done_port    = 1'b1;
        Sout_DataRdy = 2'b11;
      end
      exp_o = idle_exp();
    end
  endtask

  task automatic set_pin(input logic [32+DW-1:0] d, input logic er, input int st,
                         input int sp, input logic [2*AW-1:0] ad);
    pin_en = 1'b1; pin_data = d; pin_err = er; pin_strobe = st; pin_start = sp; pin_addr = ad;
  endtask

  // dly: WR/RD -> strobe cycle index with DataRdy; RUN -> Tn with done; -1 = never.
  task automatic run_cmd(input int op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [SW-1:0] sz, input int dly, input bit fix_rd,
                         input logic [DW-1:0] rdv, input int abort_at);
    obs_t e;
    int len;
    logic err;
    logic [32+DW-1:0] data;
    logic [DW-1:0] rd_word;
    rd_word = '0; err = 1'b0; data = '0; len = 0;
    @(posedge clock); #1;
    strays();
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_addr = a; cmd_wdata = wd; cmd_size = sz;
    exp_o = idle_exp();
    exp_on = 1'b1;
    if (op == 0 || op == 1) begin
      err = !(dly >= 0 && dly < RDT);
      len = err ? RDT : dly + 1;
      for (int j = 0; j < len; j++) begin
        @(posedge clock); #1;
        strays();
        busy_garbage();
        if (fix_rd) Sout_Rdata_ram[DW-1:0] = rdv;
        Sout_DataRdy[0] = (j == dly);
        if (j == dly) rd_word = Sout_Rdata_ram[DW-1:0];
        e = '0;
        e.oe[0] = (op == 1);
        e.we[0] = (op == 0);
        e.addr  = {{AW{1'b0}}, a};
        if (op == 0) e.wdata = {{DW{1'b0}}, wd};
        e.size  = {{SW{1'b0}}, sz};
        e.rerr  = last_err;
        e.rdata = last_data;
        exp_o = e;
        if (j == abort_at) begin
          exp_on = 1'b0;
          reset = 1'b1;
          cmd_valid = 1'b0;
          @(posedge clock); #1;
          reset = 1'b0;
          last_err = 1'b0;
          last_data = '0;
          exp_o = idle_exp();
          exp_on = 1'b1;
          return;
        end
      end
      data = err ? '0 : ((op == 1) ? {32'd0, rd_word} : '0);
    end else if (op == 2) begin
      err  = !(dly >= 0 && dly + 1 <= RUNT);
      len  = err ? RUNT : dly + 1;
      data = err ? (32+DW)'(RUNT) : (32+DW)'(dly + 1);
      for (int j = 0; j < len; j++) begin
        @(posedge clock); #1;
        strays();
        busy_garbage();
        done_port = (j == dly);
        e = '0;
        e.start = (j == 0);
        e.rerr  = last_err;
        e.rdata = last_data;
        exp_o = e;
      end
    end else begin
      err  = 1'b1;
      data = '0;
    end
    @(posedge clock); #1;
    strays();
    busy_garbage();
    last_err  = err;
    last_data = data;
    e = '0;
    e.rvalid = 1'b1;
    e.rerr   = err;
    e.rdata  = data;
    exp_o = e;
    @(posedge clock); #1;
    strays();
    cmd_valid = 1'b0;
    exp_o = idle_exp();
  endtask

  initial begin
    int op, dly;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0; cmd_size = '0;
    done_port = 1'b0; Sout_DataRdy = '0; Sout_Rdata_ram = '0;
    exp_on = 1'b0; last_err = 1'b0; last_data = '0; pin_en = 1'b0;
    pin_data = '0; pin_err = 1'b0; pin_strobe = 0; pin_start = 0; pin_addr = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    exp_o = idle_exp();
    exp_on = 1'b1;
    idle(2, 1'b0);

    run_cmd(0, 9'h055, 64'hA5A5_0000_1234_5678, 7'd32, -1, 1'b0, '0, 3);
    idle(1, 1'b0);

    set_pin('0, 1'b0, 2, 0, 18'h00010);
    run_cmd(0, 9'h010, 64'h1122334455667788, 7'd64, 1, 1'b0, '0, -1);
    set_pin(96'hDEADBEEF, 1'b0, 3, 0, 18'h00010);
    run_cmd(1, 9'h010, '0, 7'd32, 2, 1'b1, 64'hDEADBEEF, -1);
    set_pin(96'd6, 1'b0, 0, 1, '0);
    run_cmd(2, '0, '0, '0, 5, 1'b0, '0, -1);
    set_pin(96'd1, 1'b0, 0, 1, '0);
    run_cmd(2, '0, '0, '0, 0, 1'b0, '0, -1);
    set_pin('0, 1'b1, 16, 0, 18'h0001F);
    run_cmd(1, 9'h01F, '0, 7'd16, -1, 1'b0, '0, -1);
    set_pin('0, 1'b1, 0, 0, '0);
    run_cmd(3, 9'h1AB, 64'hFFFF, 7'd8, 0, 1'b0, '0, -1);
    set_pin(96'd40, 1'b1, 0, 1, '0);
    run_cmd(2, '0, '0, '0, -1, 1'b0, '0, -1);
    pin_en = 1'b0;
    idle(4, 1'b1);

    for (int k = 0; k < 80; k++) begin
      op = int'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) dly = -1;
      else if (op == 2) dly = int'($urandom_range(0, 45));
      else dly = int'($urandom_range(0, 18));
      run_cmd(op, AW'($urandom), {$urandom, $urandom}, SW'(8 << $urandom_range(0, 3)),
              dly, 1'b0, '0, -1);
      idle(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    @(negedge clock); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
